// File: rtl/ctrl_pkg.sv
// Shared constants for the control sequencer: PCSEL/WDSEL codes, opcodes,
// control-word field layout, ALU function codes and the sequencer state type.
package ctrl_pkg;

    localparam logic [2:0] PCSEL_PC4   = 3'd0;
    localparam logic [2:0] PCSEL_BR    = 3'd1;
    localparam logic [2:0] PCSEL_JMP   = 3'd2;
    localparam logic [2:0] PCSEL_ILLOP = 3'd3;
    localparam logic [2:0] PCSEL_XADR  = 3'd4;

    localparam logic [1:0] WDSEL_PC4 = 2'd0;
    localparam logic [1:0] WDSEL_ALU = 2'd1;
    localparam logic [1:0] WDSEL_MEM = 2'd2;

    localparam logic [5:0] OP_LD  = 6'h18;
    localparam logic [5:0] OP_ST  = 6'h19;
    localparam logic [5:0] OP_JMP = 6'h1B;
    localparam logic [5:0] OP_BEQ = 6'h1D;
    localparam logic [5:0] OP_BNE = 6'h1E;
    localparam logic [5:0] OP_LDR = 6'h1F;

    // Opcode bits above the low nibble select the register / constant ALU groups.
    localparam logic [1:0] OP_GRP_ALU  = 2'b10;
    localparam logic [1:0] OP_GRP_ALUC = 2'b11;

    localparam int ALU_CODE_W = 6;
    localparam logic [5:0] ALUFN_ADD   = 6'h00;
    localparam logic [5:0] ALUFN_SUB   = 6'h01;
    localparam logic [5:0] ALUFN_MUL   = 6'h02;
    localparam logic [5:0] ALUFN_DIV   = 6'h03;
    localparam logic [5:0] ALUFN_CMPEQ = 6'h33;
    localparam logic [5:0] ALUFN_CMPLT = 6'h35;
    localparam logic [5:0] ALUFN_CMPLE = 6'h37;
    localparam logic [5:0] ALUFN_AND   = 6'h18;
    localparam logic [5:0] ALUFN_OR    = 6'h1E;
    localparam logic [5:0] ALUFN_XOR   = 6'h16;
    localparam logic [5:0] ALUFN_XNOR  = 6'h19;
    localparam logic [5:0] ALUFN_A     = 6'h1A;
    localparam logic [5:0] ALUFN_SHL   = 6'h20;
    localparam logic [5:0] ALUFN_SHR   = 6'h21;
    localparam logic [5:0] ALUFN_SRA   = 6'h23;

    localparam int CW_WASEL   = 0;
    localparam int CW_WERF    = 1;
    localparam int CW_WR      = 2;
    localparam int CW_WDSEL   = 3;
    localparam int CW_BSEL    = 5;
    localparam int CW_ASEL    = 6;
    localparam int CW_RA2SEL  = 7;
    localparam int CW_PCSEL   = 8;
    localparam int CW_ALUFN   = 11;
    localparam int CW_ILLEGAL = 17;
    localparam int CW_W       = 18;

    typedef enum logic [1:0] {
        ST_RST,
        ST_RUN,
        ST_IRQ
    } ctrl_state_t;

    function automatic logic [CW_W-1:0] cw_pack(
        input logic       illegal,
        input logic [5:0] alufn,
        input logic [2:0] pcsel,
        input logic       ra2sel,
        input logic       asel,
        input logic       bsel,
        input logic [1:0] wdsel,
        input logic       wr,
        input logic       werf,
        input logic       wasel
    );
        return {illegal, alufn, pcsel, ra2sel, asel, bsel, wdsel, wr, werf, wasel};
    endfunction

    // Low opcode nibble -> {valid, ALUFN}; unused nibbles come back invalid.
    function automatic logic [6:0] alu_lookup(input logic [3:0] sub);
        logic [6:0] r;
        case (sub)
            4'h0:    r = {1'b1, ALUFN_ADD};
            4'h1:    r = {1'b1, ALUFN_SUB};
            4'h2:    r = {1'b1, ALUFN_MUL};
            4'h3:    r = {1'b1, ALUFN_DIV};
            4'h4:    r = {1'b1, ALUFN_CMPEQ};
            4'h5:    r = {1'b1, ALUFN_CMPLT};
            4'h6:    r = {1'b1, ALUFN_CMPLE};
            4'h8:    r = {1'b1, ALUFN_AND};
            4'h9:    r = {1'b1, ALUFN_OR};
            4'hA:    r = {1'b1, ALUFN_XOR};
            4'hB:    r = {1'b1, ALUFN_XNOR};
            4'hC:    r = {1'b1, ALUFN_SHL};
            4'hD:    r = {1'b1, ALUFN_SHR};
            4'hE:    r = {1'b1, ALUFN_SRA};
            default: r = {1'b0, ALUFN_ADD};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ctrl_irq_arbiter.sv
// Interrupt pending latches, mask register and priority select with registered ack/id.
// CTRL_ROUND_ROBIN_EN switches from fixed lowest-index priority to rotating priority.
module ctrl_irq_arbiter #(
    parameter int NUM_IRQ = 4,
    parameter int IDW     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               take_en,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_in,
    output logic               take,
    output logic [NUM_IRQ-1:0] ack,
    output logic [IDW-1:0]     irq_id,
    output logic [NUM_IRQ-1:0] mask
);

    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] grant;
    logic [IDW-1:0]     sel;

    assign eligible = pend & mask;
    assign take     = take_en & (|eligible);
    assign grant    = take ? (NUM_IRQ'(1) << sel) : '0;

`ifdef CTRL_ROUND_ROBIN_EN
    logic [IDW-1:0]     ptr;
    logic [NUM_IRQ-1:0] rot;

    function automatic logic [IDW-1:0] wrap_idx(input int v);
        return IDW'((v >= NUM_IRQ) ? v - NUM_IRQ : v);
    endfunction

    // Rotate so bit 0 is the line after the last one served, then take the lowest.
    always_comb begin
        rot = NUM_IRQ'({eligible, eligible} >> ptr);
        sel = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (rot[i]) sel = wrap_idx(int'(ptr) + i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)     ptr <= '0;
        else if (take) ptr <= wrap_idx(int'(sel) + 1);
    end
`else
    always_comb begin
        sel = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) sel = IDW'(i);
        end
    end
`endif

    // A request arriving in the grant cycle re-sets the line, so set wins over clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend   <= '0;
            mask   <= '0;
            ack    <= '0;
            irq_id <= '0;
        end else begin
            pend <= (pend & ~grant) | irq_req;
            ack  <= grant;
            if (mask_we) mask   <= mask_in;
            if (take)    irq_id <= sel;
        end
    end

endmodule

// File: rtl/ctrl_seq_unit.sv
// Registered control decoder: opcode ROM, branch resolve, ILLOP trap and interrupt take.
// Define CTRL_ROUND_ROBIN_EN for rotating interrupt priority.
module ctrl_seq_unit #(
    parameter int OPW     = 6,
    parameter int NUM_IRQ = 4,
    parameter int ALUFN_W = 6,
    parameter int IDW     = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [OPW-1:0]     OPCODE,
    input  logic               INSTR_VALID,
    input  logic               Z,
    input  logic               SUPERVISOR,
    input  logic [NUM_IRQ-1:0] IRQ_REQ,
    input  logic               IRQ_MASK_WE,
    input  logic [NUM_IRQ-1:0] IRQ_MASK_IN,
    output logic               CTRL_VALID,
    output logic [2:0]         PCSEL,
    output logic               RA2SEL,
    output logic               ASEL,
    output logic               BSEL,
    output logic [1:0]         WDSEL,
    output logic [ALUFN_W-1:0] ALUFN,
    output logic               WR,
    output logic               WERF,
    output logic               WASEL,
    output logic [NUM_IRQ-1:0] IRQ_ACK,
    output logic [IDW-1:0]     IRQ_ID,
    output logic [NUM_IRQ-1:0] IRQ_MASK
);
    import ctrl_pkg::*;

    ctrl_state_t     state;
    logic            take_en;
    logic            take;
    logic [CW_W-1:0] rom_out;
    logic            is_beq;
    logic            is_bne;

    // Decode ROM; anything not listed is flagged illegal.
    function automatic logic [CW_W-1:0] rom_word(input logic [OPW-1:0] op);
        logic [6:0]      alu;
        logic [CW_W-1:0] w;
        alu = alu_lookup(op[3:0]);
        w   = cw_pack(1'b1, ALUFN_ADD, PCSEL_ILLOP, 1'b0, 1'b0, 1'b0, WDSEL_PC4, 1'b0, 1'b1, 1'b1);
        if (op == OPW'(OP_LD))
            w = cw_pack(1'b0, ALUFN_ADD, PCSEL_PC4, 1'b0, 1'b0, 1'b1, WDSEL_MEM, 1'b0, 1'b1, 1'b0);
        else if (op == OPW'(OP_ST))
            w = cw_pack(1'b0, ALUFN_ADD, PCSEL_PC4, 1'b1, 1'b0, 1'b1, WDSEL_PC4, 1'b1, 1'b0, 1'b0);
        else if (op == OPW'(OP_JMP))
            w = cw_pack(1'b0, ALUFN_ADD, PCSEL_JMP, 1'b0, 1'b0, 1'b0, WDSEL_PC4, 1'b0, 1'b1, 1'b0);
        else if (op == OPW'(OP_BEQ) || op == OPW'(OP_BNE))
            w = cw_pack(1'b0, ALUFN_ADD, PCSEL_PC4, 1'b0, 1'b0, 1'b0, WDSEL_PC4, 1'b0, 1'b1, 1'b0);
        else if (op == OPW'(OP_LDR))
            w = cw_pack(1'b0, ALUFN_A, PCSEL_PC4, 1'b0, 1'b1, 1'b0, WDSEL_MEM, 1'b0, 1'b1, 1'b0);
        else if (op[OPW-1:4] == (OPW-4)'(OP_GRP_ALU) && alu[6])
            w = cw_pack(1'b0, alu[5:0], PCSEL_PC4, 1'b0, 1'b0, 1'b0, WDSEL_ALU, 1'b0, 1'b1, 1'b0);
        else if (op[OPW-1:4] == (OPW-4)'(OP_GRP_ALUC) && alu[6])
            w = cw_pack(1'b0, alu[5:0], PCSEL_PC4, 1'b0, 1'b0, 1'b1, WDSEL_ALU, 1'b0, 1'b1, 1'b0);
        return w;
    endfunction

    assign rom_out = rom_word(OPCODE);
    assign is_beq  = (OPCODE == OPW'(OP_BEQ));
    assign is_bne  = (OPCODE == OPW'(OP_BNE));
    // The IRQ state blocks a second take while the XADR word is still in flight.
    assign take_en = INSTR_VALID & ~SUPERVISOR & (state != ST_IRQ);

    ctrl_irq_arbiter #(
        .NUM_IRQ (NUM_IRQ),
        .IDW     (IDW)
    ) u_arb (
        .clk     (CLK),
        .reset   (RESET),
        .take_en (take_en),
        .irq_req (IRQ_REQ),
        .mask_we (IRQ_MASK_WE),
        .mask_in (IRQ_MASK_IN),
        .take    (take),
        .ack     (IRQ_ACK),
        .irq_id  (IRQ_ID),
        .mask    (IRQ_MASK)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= ST_RST;
            CTRL_VALID <= 1'b0;
            PCSEL      <= '0;
            RA2SEL     <= 1'b0;
            ASEL       <= 1'b0;
            BSEL       <= 1'b0;
            WDSEL      <= '0;
            ALUFN      <= '0;
            WR         <= 1'b0;
            WERF       <= 1'b0;
            WASEL      <= 1'b0;
        end else begin
            CTRL_VALID <= INSTR_VALID;
            state      <= take ? ST_IRQ : ST_RUN;
            if (take) begin
                PCSEL <= PCSEL_XADR;
                WDSEL <= WDSEL_PC4;
                WERF  <= 1'b1;
                WASEL <= 1'b1;
                WR    <= 1'b0;
            end else if (!INSTR_VALID) begin
                PCSEL <= PCSEL_PC4;
                WR    <= 1'b0;
                WERF  <= 1'b0;
            end else if (rom_out[CW_ILLEGAL]) begin
                PCSEL <= PCSEL_ILLOP;
                WDSEL <= WDSEL_PC4;
                WERF  <= 1'b1;
                WASEL <= 1'b1;
                WR    <= 1'b0;
            end else begin
                if (is_beq)      PCSEL <= Z ? PCSEL_BR : PCSEL_PC4;
                else if (is_bne) PCSEL <= Z ? PCSEL_PC4 : PCSEL_BR;
                else             PCSEL <= rom_out[CW_PCSEL +: 3];
                ALUFN  <= ALUFN_W'(rom_out[CW_ALUFN +: ALU_CODE_W]);
                RA2SEL <= rom_out[CW_RA2SEL];
                ASEL   <= rom_out[CW_ASEL];
                BSEL   <= rom_out[CW_BSEL];
                WDSEL  <= rom_out[CW_WDSEL +: 2];
                WR     <= rom_out[CW_WR];
                WERF   <= rom_out[CW_WERF];
                WASEL  <= rom_out[CW_WASEL];
            end
        end
    end

endmodule

// File: doc/ctrl_seq_unit.md
Name: ctrl_seq_unit

Overview:
- Registered, parametrised successor to the processor's combinational opcode-ROM control decoder.
- Decodes the 6-bit opcode into the full datapath control word, one cycle after the instruction is presented.
- Adds a multi-line interrupt controller: pending latches, mask register, priority arbitration, acknowledge pulse.
- Traps illegal opcodes; uses an explicit instruction-valid handshake. Sits between instruction fetch and the datapath muxes/regfile/memory.

Parameters:
- OPW, 6, opcode width; decode ROM depth is 2**OPW.
- NUM_IRQ, 4, number of interrupt request lines (1..16).
- ALUFN_W, 6, ALU function field width.
- IDW, 4, width of IRQ_ID; must satisfy 2**IDW >= NUM_IRQ.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- OPCODE  in  OPW  opcode of the instruction being presented.
- INSTR_VALID  in  1  OPCODE/Z are valid this cycle; the instruction is consumed on this edge.
- Z  in  1  register-file operand-zero flag for BEQ/BNE.
- SUPERVISOR  in  1  PC supervisor bit; interrupts are not taken while high.
- IRQ_REQ  in  NUM_IRQ  level/pulse interrupt requests.
- IRQ_MASK_WE  in  1  load IRQ_MASK from IRQ_MASK_IN.
- IRQ_MASK_IN  in  NUM_IRQ  new mask value; 1 = enabled.
- CTRL_VALID  out  1  registered control word below is valid.
- PCSEL  out  3  0=PC+4, 1=branch, 2=JMP, 3=ILLOP vector, 4=XADR (interrupt).
- RA2SEL, ASEL, BSEL  out  1 each  datapath mux selects.
- WDSEL  out  2  write-data select; 0=PC+4, 1=ALU, 2=memory.
- ALUFN  out  ALUFN_W  ALU function.
- WR  out  1  memory write enable.
- WERF  out  1  register-file write enable.
- WASEL  out  1  write-address select; 1=XP.
- IRQ_ACK  out  NUM_IRQ  one-hot, one-cycle acknowledge of the line taken.
- IRQ_ID  out  IDW  index of the last interrupt taken; held until the next one.
- IRQ_MASK  out  NUM_IRQ  current mask register.

Behaviour:
- Reset: while RESET is sampled high, all outputs are 0 on the next edge (CTRL_VALID, PCSEL, WR, WERF, IRQ_ACK, IRQ_ID, IRQ_MASK included). Pending latches and the round-robin pointer clear.
- Reset mid-instruction: the in-flight control word is discarded; WR/WERF are never asserted in the cycle after RESET.
- Latency: the control word appears one cycle after an edge with INSTR_VALID=1; CTRL_VALID is INSTR_VALID delayed by one.
- Bubbles: an edge with INSTR_VALID=0 produces CTRL_VALID=0, WR=0, WERF=0, PCSEL=0; other fields hold their values.
- Pending: pend <= (pend & ~ack) | IRQ_REQ. A request on the same line in the ack cycle stays pending (set wins).
- Mask: IRQ_MASK_WE loads the mask on the edge; arbitration in that same cycle uses the old mask.
- Take condition: INSTR_VALID & ~SUPERVISOR & |(pend & mask).
  - Lowest index wins.
  - The presented instruction is suppressed (not executed).
  - Control word: PCSEL=4, WDSEL=0, WERF=1, WASEL=1, WR=0.
  - IRQ_ACK bit and IRQ_ID update in the same output cycle.
- Illegal opcode (ROM entry flagged unused), no interrupt taken: PCSEL=3, WDSEL=0, WERF=1, WASEL=1, WR=0.
- Interrupt and illegal opcode in the same cycle: the interrupt wins.
- BEQ (0x1D): PCSEL = {2'b00, Z}. BNE (0x1E): PCSEL = {2'b00, ~Z}. Z is sampled on the INSTR_VALID edge.
- All other opcodes: control word taken directly from the decode ROM. The ROM holds ALUFN, PCSEL, RA2SEL, ASEL, BSEL, WDSEL, WR, WERF, WASEL and an illegal flag.
- States:
  - RST: RESET high.
  - RUN: normal decode.
  - IRQ: an interrupt word is being emitted.
  - Transitions: RST->RUN on RESET low; RUN->IRQ on the take condition; IRQ->RUN after one cycle.
  - Back-to-back takes: two back-to-back takes are impossible, because IRQ sets SUPERVISOR via XADR. The bench must still not see two IRQ_ACK pulses on consecutive cycles.

Optional Feature:
- CTRL_ROUND_ROBIN_EN defined: rotating priority. The search starts at (last IRQ_ID+1) mod NUM_IRQ, giving fairness among simultaneously pending lines.
- Undefined: fixed priority, lowest index wins; no pointer register.

Decomposition:
- ctrl_pkg holds:
  - PCSEL_* and WDSEL_* constants;
  - OP_BEQ, OP_BNE, OP_LD, OP_ST, OP_JMP, OP_LDR localparams;
  - control-word field offsets/width;
  - ALUFN codes.
- Sub-module ctrl_irq_arbiter: pending latches, mask register, fixed/round-robin select, one-hot ack, id encode.
- ctrl_seq_unit keeps the decode ROM, the FSM and the output registers.

Test Plan:
- Reset: RESET=1 for 2 cycles with INSTR_VALID=1, OPCODE=0x19 (ST) -> WR=0, WERF=0, CTRL_VALID=0, IRQ_MASK=0 throughout; the first decode appears 1 cycle after RESET falls.
- Branch: OPCODE=0x1D with Z=1 -> PCSEL=1; Z=0 -> PCSEL=0. OPCODE=0x1E with Z=0 -> PCSEL=1; Z=1 -> PCSEL=0. Each response appears exactly 1 cycle later.
- Illegal: OPCODE=0x00 with no IRQ -> PCSEL=3, WERF=1, WASEL=1, WR=0.
- IRQ priority: mask=4'b1111, IRQ_REQ=4'b1010 pulse, SUPERVISOR=0, OPCODE=0x20 -> PCSEL=4, IRQ_ACK=4'b0010, IRQ_ID=1. Line 3 stays pending; with SUPERVISOR=1 it is not taken. After SUPERVISOR=0 -> IRQ_ACK=4'b1000, IRQ_ID=3.
- Mask/race:
  - IRQ_MASK_WE with IN=0 in the same cycle as a pending enabled line -> the interrupt is still taken (old mask).
  - Afterwards, new requests stay pending and are not taken.
  - A re-request in the ack cycle -> pending retained.
- Round-robin (CTRL_ROUND_ROBIN_EN): IRQ_REQ=4'b1111 held, repeated takes -> IRQ_ID sequence 0,1,2,3,0. With the macro undefined -> always 0.
